// File: rtl/st2_sign_extend.sv
// Stage-2 immediate generator: extends the 12-bit instruction operand field to 16 bits
// in one of four modes and registers the result for the stage-2/stage-3 operand path.
module st2_sign_extend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] origInstruction,
    input  logic [1:0]  SE_Sel,
    output logic [15:0] extended
);

    typedef enum logic [1:0] {
        SelSext4  = 2'b00,
        SelSext8  = 2'b01,
        SelSext12 = 2'b10,
        SelZext8  = 2'b11
    } se_sel_e;

    se_sel_e     sel;
    logic [15:0] ext_d;
    logic [15:0] ext_q;

    assign sel = se_sel_e'(SE_Sel);

    // Unrecognised select values fall back to the 4-bit sign-extend path.
    always_comb begin
        ext_d = {{12{origInstruction[3]}}, origInstruction[3:0]};
        case (sel)
            SelSext4:  ext_d = {{12{origInstruction[3]}}, origInstruction[3:0]};
            SelSext8:  ext_d = {{8{origInstruction[7]}}, origInstruction[7:0]};
            SelSext12: ext_d = {{4{origInstruction[11]}}, origInstruction[11:0]};
            SelZext8:  ext_d = {8'h00, origInstruction[7:0]};
            default:   ext_d = {{12{origInstruction[3]}}, origInstruction[3:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_q <= 16'h0000;
        end else begin
            ext_q <= ext_d;
        end
    end

    assign extended = ext_q;

endmodule

// File: tb/tb_st2_sign_extend.sv
// Bench for st2_sign_extend: directed vectors, mid-cycle glitches and randomized traffic
// checked against an arithmetic reference model.
module tb_st2_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [11:0] oi;
    logic [1:0]  sel;
    logic [15:0] extended;

    int total;
    int bad;

    st2_sign_extend dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .origInstruction (oi),
        .SE_Sel          (sel),
        .extended        (extended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two's-complement value of the selected field, reduced modulo 2^16.
    function automatic logic [15:0] ref_ext(input logic [11:0] f, input logic [1:0] m);
        int u;
        int v;
        u = int'(f);
        case (m)
            2'd0: begin v = u % 16;  if (v >= 8)    v = v - 16;   end
            2'd1: begin v = u % 256; if (v >= 128)  v = v - 256;  end
            2'd2: begin v = u;       if (v >= 2048) v = v - 4096; end
            default: v = u % 256;
        endcase
        if (v < 0) v = v + 65536;
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present inputs, take one edge, check the registered result just after it.
    task automatic step(input logic r, input logic [11:0] f, input logic [1:0] m,
                        input logic [15:0] exp, input string tag);
        rst_n = r;
        oi    = f;
        sel   = m;
        @(posedge clk);
        #1;
        check(tag, extended, exp);
    endtask

    logic [15:0] hold;
    logic [11:0] rf;
    logic [1:0]  rm;
    logic        rr;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        oi    = 12'hFFF;
        sel   = 2'b10;

        step(1'b0, 12'hFFF, 2'b10, 16'h0000, "reset_edge1");
        step(1'b0, 12'hFFF, 2'b10, 16'h0000, "reset_edge2");
        step(1'b1, 12'hFFF, 2'b10, 16'hFFFF, "reset_release");

        // Back-to-back mode changes, one result per edge.
        step(1'b1, 12'hF01, 2'b00, 16'h0001, "m00_pos");
        step(1'b1, 12'h00F, 2'b00, 16'hFFFF, "m00_neg");
        step(1'b1, 12'h008, 2'b01, 16'h0008, "m01_pos");
        step(1'b1, 12'h080, 2'b01, 16'hFF80, "m01_neg");
        step(1'b1, 12'hF7C, 2'b10, 16'hFF7C, "m10_neg");
        step(1'b1, 12'h7FF, 2'b10, 16'h07FF, "m10_pos");
        step(1'b1, 12'hFAC, 2'b11, 16'h00AC, "m11_zext");

        // Input glitch between edges must not reach the output.
        hold = extended;
        oi   = 12'h0F0;
        sel  = 2'b01;
        #2;
        check("glitch_hold", extended, hold);
        step(1'b1, 12'h800, 2'b10, 16'hF800, "post_glitch");

        // Reset asserted between edges only takes effect at the next edge.
        rst_n = 1'b0;
        #2;
        check("reset_async_hold", extended, 16'hF800);
        step(1'b0, 12'h00F, 2'b00, 16'h0000, "reset_mid");
        step(1'b1, 12'h00F, 2'b00, 16'hFFFF, "reset_mid_release");

        for (int i = 0; i < 300; i++) begin
            rf = 12'($urandom);
            rm = 2'($urandom);
            rr = ($urandom_range(0, 15) != 0);
            step(rr, rf, rm, rr ? ref_ext(rf, rm) : 16'h0000, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
